// File: rtl/self_destruct_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : self_destruct_ctrl
//  Description : Sequencing controller for the self-destruct countdown.
//                Arms on a 2-of-3 critical condition while in combat, runs a
//                thermometer-fill LED countdown, pauses (HOLD) when the
//                critical condition drops, aborts to SAFE, and fires when the
//                bar is full. All outputs are registered.
//                Optional feature macro: SELF_DESTRUCT_BLINK_EN (LED blinking
//                in COUNT and FIRE, driven by tick_blink).
//  Revision    : 1.0 - initial release
// ============================================================================
module self_destruct_ctrl #(
   parameter int ARM_TICKS  = 2,
   parameter int HOLD_TICKS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1s,
   input  logic       tick_blink,
   input  logic       in_combat,
   input  logic       danger,
   input  logic       damaged,
   input  logic       immobilized,
   input  logic       abort,
   output logic [7:0] leds,
   output logic       fire,
   output logic [2:0] state,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMING = 3'd1,
      S_COUNT  = 3'd2,
      S_HOLD   = 3'd3,
      S_FIRE   = 3'd4,
      S_SAFE   = 3'd5
   } state_t;

   localparam int ARM_W  = (ARM_TICKS  > 1) ? $clog2(ARM_TICKS)  : 1;
   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

   state_t            state_q, state_d;
   logic [7:0]        pattern_q, pattern_d;
   logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              fire_q, fire_d;
   logic [7:0]        leds_q, leds_d;
   logic              busy_q, busy_d;
   logic              phase_d;
   logic              crit;

   // Majority vote of the three hazard flags (inputs are already synchronous).
   assign crit = (danger & damaged) | (danger & immobilized) | (damaged & immobilized);

   // Next-state, countdown pattern and counters.
   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      arm_cnt_d  = arm_cnt_q;
      hold_cnt_d = hold_cnt_q;
      fire_d     = fire_q;
      case (state_q)
         S_IDLE: begin
            pattern_d = 8'h00;
            if (in_combat && crit && !abort) begin
               state_d   = S_ARMING;
               arm_cnt_d = '0;
            end
         end
         S_ARMING: begin
            if (abort) begin
               state_d   = S_SAFE;
               pattern_d = 8'h00;
            end else if (!in_combat || !crit) begin
               state_d   = S_IDLE;
            end else if (tick_1s) begin
               if (arm_cnt_q == ARM_LAST) begin
                  state_d   = S_COUNT;
                  pattern_d = 8'h01;
               end else begin
                  arm_cnt_d = arm_cnt_q + ARM_W'(1);
               end
            end
         end
         S_COUNT: begin
            if (abort || !in_combat) begin
               state_d   = S_SAFE;
               pattern_d = 8'h00;
            end else if (!crit) begin
               // Pattern freezes; a coincident tick is intentionally dropped.
               state_d    = S_HOLD;
               hold_cnt_d = '0;
            end else if (tick_1s) begin
               if (pattern_q == 8'hFF) begin
                  state_d = S_FIRE;
                  fire_d  = 1'b1;
               end else begin
                  pattern_d = {pattern_q[6:0], 1'b1};
               end
            end
         end
         S_HOLD: begin
            if (abort || !in_combat) begin
               state_d   = S_SAFE;
               pattern_d = 8'h00;
            end else if (crit) begin
               // Resume without advancing, even if a tick arrives now.
               state_d = S_COUNT;
            end else if (tick_1s) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d   = S_SAFE;
                  pattern_d = 8'h00;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
         end
         S_FIRE: begin
            fire_d    = 1'b1;
            pattern_d = 8'hFF;
         end
         S_SAFE: begin
            pattern_d = 8'h00;
            // Combat must end before the controller can re-arm.
            if (!in_combat && !abort) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pattern_d = 8'h00;
         end
      endcase
   end

`ifdef SELF_DESTRUCT_BLINK_EN
   logic phase_q;

   // Blink phase toggles only while counting or fired; elsewhere it is held on.
   always_comb begin
      phase_d = 1'b1;
      if (state_q == S_COUNT || state_q == S_FIRE) begin
         phase_d = tick_blink ? ~phase_q : phase_q;
      end
   end

   // Blink phase register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q <= 1'b1;
      end else begin
         phase_q <= phase_d;
      end
   end
`else
   logic unused_tick_blink;
   assign unused_tick_blink = tick_blink;
   assign phase_d           = 1'b1;
`endif

   // Output values computed from the next state so the flops show them directly.
   always_comb begin
      leds_d = pattern_d & {8{phase_d}};
      busy_d = (state_d == S_ARMING) || (state_d == S_COUNT) || (state_d == S_HOLD);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pattern_q  <= 8'h00;
         arm_cnt_q  <= '0;
         hold_cnt_q <= '0;
         fire_q     <= 1'b0;
         leds_q     <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         arm_cnt_q  <= arm_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         fire_q     <= fire_d;
         leds_q     <= leds_d;
         busy_q     <= busy_d;
      end
   end

   assign leds  = leds_q;
   assign fire  = fire_q;
   assign state = state_q;
   assign busy  = busy_q;

endmodule
`default_nettype wire
